// File: rtl/cordic_disp_pkg.sv
// ---------------------------------------------------------------------------
// cordic_disp_pkg
// Shared definitions for the CORDIC result display path: ASCII character
// codes used by the formatter, the formatter FSM state encoding and the
// "+0.000" string shown after reset.
// ---------------------------------------------------------------------------
package cordic_disp_pkg;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_I = 2'd2,
    DONE   = 2'd3
  } disp_state_e;

  // Default string for three fraction digits. The first three characters
  // ("+0.") are the same for any fraction length.
  localparam logic [47:0] DEFAULT_STR = {ASCII_PLUS, ASCII_ZERO, ASCII_DOT,
                                         ASCII_ZERO, ASCII_ZERO, ASCII_ZERO};

  // Decimal digit value (0..9) to its ASCII code.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'b0000, d};
  endfunction

endpackage

// File: rtl/cordic_result_ascii_fmt_frac_digit_step.sv
// ---------------------------------------------------------------------------
// frac_digit_step
// Purely combinational step of the binary-fraction to decimal conversion:
// multiplies the remaining fraction by ten; the bits above the binary point
// form the next decimal digit and the bits below it are the new fraction.
// Truncating, no rounding.
//
// Ports:
//   f_in     in  FRAC_BITS  remaining fraction (unsigned, 0 <= f < 1)
//   digit    out 4          next decimal digit, always 0..9
//   f_next   out FRAC_BITS  fraction left over after this digit
// ---------------------------------------------------------------------------
module frac_digit_step #(
  parameter int FRAC_BITS = 14
) (
  input  logic [FRAC_BITS-1:0] f_in,
  output logic [3:0]           digit,
  output logic [FRAC_BITS-1:0] f_next
);

  logic [FRAC_BITS+3:0] f_ext;
  logic [FRAC_BITS+3:0] prod;

  // f*10 as (f<<3)+(f<<1); since f < 2^FRAC_BITS the product stays below
  // 10*2^FRAC_BITS, so four extra bits hold it without overflow.
  always_comb begin
    f_ext  = {4'b0000, f_in};
    prod   = (f_ext << 3) + (f_ext << 1);
    digit  = prod[FRAC_BITS+3:FRAC_BITS];
    f_next = prod[FRAC_BITS-1:0];
  end

endmodule

// File: rtl/cordic_result_ascii_fmt.sv
// ---------------------------------------------------------------------------
// cordic_result_ascii_fmt
// Turns the signed fixed-point CORDIC sine (Q) and cosine (I) results into
// fixed-width ASCII strings "sD.ddd" for the VGA text renderer. A single
// digit-step datapath is shared: Q fraction digits first, then I, one digit
// per clock. Both output strings are loaded together on the edge that
// raises done, so the renderer never sees a half-converted string.
//
// Ports:
//   clk       in   1                    clock, rising edge
//   reset     in   1                    synchronous, active-high reset
//   start     in   1                    convert q_in/i_in (honoured in IDLE)
//   q_in      in   WIDTH                signed Q (sin) result
//   i_in      in   WIDTH                signed I (cos) result
//   busy      out  1                    high while not IDLE
//   done      out  1                    one-cycle pulse, strings updated
//   q_val_op  out  8*(FRAC_DIGITS+3)    Q string, first char in MSByte
//   i_val_op  out  8*(FRAC_DIGITS+3)    I string, same format
// ---------------------------------------------------------------------------
module cordic_result_ascii_fmt
  import cordic_disp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 14,
  parameter int FRAC_DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             q_in,
  input  logic [WIDTH-1:0]             i_in,
  output logic                         busy,
  output logic                         done,
  output logic [8*(FRAC_DIGITS+3)-1:0] q_val_op,
  output logic [8*(FRAC_DIGITS+3)-1:0] i_val_op
);

  localparam int STR_W = 8 * (FRAC_DIGITS + 3);
  localparam int DIG_W = 8 * FRAC_DIGITS;
  localparam int INT_W = WIDTH + 1 - FRAC_BITS;
  localparam int CNT_W = (FRAC_DIGITS > 1) ? $clog2(FRAC_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_DIGITS - 1);
  localparam logic [STR_W-1:0] RESET_STR =
    {DEFAULT_STR[47:24], {FRAC_DIGITS{ASCII_ZERO}}};

  disp_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 q_neg_q, q_neg_d, i_neg_q, i_neg_d;
  logic [INT_W-1:0]     q_int_q, q_int_d, i_int_q, i_int_d;
  logic [FRAC_BITS-1:0] q_frac_q, q_frac_d, i_frac_q, i_frac_d;
  logic [DIG_W-1:0]     q_dig_q, q_dig_d, i_dig_q, i_dig_d;
  logic [STR_W-1:0]     q_val_q, q_val_d, i_val_q, i_val_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic [WIDTH:0]       q_mag, i_mag;
  logic [FRAC_BITS-1:0] step_f, step_f_next;
  logic [3:0]           step_digit;
  logic [7:0]           step_char;
  logic [DIG_W-1:0]     i_dig_last;

  frac_digit_step #(.FRAC_BITS(FRAC_BITS)) u_step (
    .f_in   (step_f),
    .digit  (step_digit),
    .f_next (step_f_next)
  );

  // Magnitudes are formed one bit wider than the input so the most negative
  // value (-2^(WIDTH-1)) negates to +2^(WIDTH-1) instead of wrapping.
  always_comb begin
    q_mag = q_in[WIDTH-1] ? (~{q_in[WIDTH-1], q_in} + (WIDTH+1)'(1))
                          : {1'b0, q_in};
    i_mag = i_in[WIDTH-1] ? (~{i_in[WIDTH-1], i_in} + (WIDTH+1)'(1))
                          : {1'b0, i_in};
  end

  // Next-state logic: sample inputs in IDLE, step Q then I fractions
  // through the shared digit datapath, and publish both strings together
  // on the final I digit. The last I character is taken straight from the
  // datapath so the strings land on the same edge that raises done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    i_neg_d  = i_neg_q;
    q_int_d  = q_int_q;
    i_int_d  = i_int_q;
    q_frac_d = q_frac_q;
    i_frac_d = i_frac_q;
    q_dig_d  = q_dig_q;
    i_dig_d  = i_dig_q;
    q_val_d  = q_val_q;
    i_val_d  = i_val_q;
    done_d   = 1'b0;

    step_f     = (state_q == CONV_Q) ? q_frac_q : i_frac_q;
    step_char  = digit_char(step_digit);
    i_dig_last = DIG_W'({i_dig_q, step_char});

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CONV_Q;
          cnt_d    = '0;
          q_neg_d  = q_in[WIDTH-1];
          i_neg_d  = i_in[WIDTH-1];
          q_int_d  = q_mag[WIDTH:FRAC_BITS];
          i_int_d  = i_mag[WIDTH:FRAC_BITS];
          q_frac_d = q_mag[FRAC_BITS-1:0];
          i_frac_d = i_mag[FRAC_BITS-1:0];
        end
      end
      CONV_Q: begin
        q_frac_d = step_f_next;
        q_dig_d  = DIG_W'({q_dig_q, step_char});
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CONV_I;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONV_I: begin
        i_frac_d = step_f_next;
        i_dig_d  = i_dig_last;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          done_d  = 1'b1;
          q_val_d = {(q_neg_q ? ASCII_MINUS : ASCII_PLUS),
                     ASCII_ZERO + 8'(q_int_q), ASCII_DOT, q_dig_q};
          i_val_d = {(i_neg_q ? ASCII_MINUS : ASCII_PLUS),
                     ASCII_ZERO + 8'(i_int_q), ASCII_DOT, i_dig_last};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any conversion in flight and
  // restores the default strings without producing a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      i_neg_q  <= 1'b0;
      q_int_q  <= '0;
      i_int_q  <= '0;
      q_frac_q <= '0;
      i_frac_q <= '0;
      q_dig_q  <= '0;
      i_dig_q  <= '0;
      q_val_q  <= RESET_STR;
      i_val_q  <= RESET_STR;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      i_neg_q  <= i_neg_d;
      q_int_q  <= q_int_d;
      i_int_q  <= i_int_d;
      q_frac_q <= q_frac_d;
      i_frac_q <= i_frac_d;
      q_dig_q  <= q_dig_d;
      i_dig_q  <= i_dig_d;
      q_val_q  <= q_val_d;
      i_val_q  <= i_val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign q_val_op = q_val_q;
  assign i_val_op = i_val_q;

endmodule

// File: tb/tb_cordic_result_ascii_fmt.sv
// ---------------------------------------------------------------------------
// tb_cordic_result_ascii_fmt
// Directed bench for the CORDIC result ASCII formatter: reset strings,
// several conversions with hand-computed strings, done/busy timing, start
// held high, input changes mid-conversion, reset abort and output hold.
// ---------------------------------------------------------------------------
module tb_cordic_result_ascii_fmt;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] q_in;
  logic [15:0] i_in;
  logic        busy;
  logic        done;
  logic [47:0] q_val_op;
  logic [47:0] i_val_op;

  int compared   = 0;
  int mismatched = 0;

  cordic_result_ascii_fmt #(
    .WIDTH       (16),
    .FRAC_BITS   (14),
    .FRAC_DIGITS (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .q_in     (q_in),
    .i_in     (i_in),
    .busy     (busy),
    .done     (done),
    .q_val_op (q_val_op),
    .i_val_op (i_val_op)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, wanted %h", tag, observed, expected);
    end
  endtask

  // Start one conversion, scramble the inputs right after the start edge,
  // and wait (bounded) for done. lat counts edges after the start edge;
  // stable reports whether both outputs held their old strings meanwhile.
  task automatic applyStimulus(input logic [15:0] q, input logic [15:0] i,
                               output int lat, output logic stable);
    logic [47:0] q_prev, i_prev;
    q_prev = q_val_op;
    i_prev = i_val_op;
    q_in   = q;
    i_in   = i;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    q_in   = ~q;
    i_in   = ~i;
    lat    = 0;
    stable = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (q_val_op !== q_prev || i_val_op !== i_prev) stable = 1'b0;
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [15:0] q;
    logic [15:0] i;
    logic [47:0] q_str;
    logic [47:0] i_str;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int          lat;
    int          n;
    logic        stable;
    logic        seen_done;

    vecs[0] = '{16'h2D41, 16'hD2BF, "+0.707", "-0.707"};
    vecs[1] = '{16'h4000, 16'h8000, "+1.000", "-2.000"};
    vecs[2] = '{16'h7FFF, 16'hFFFF, "+1.999", "-0.000"};

    reset = 1'b1;
    start = 1'b0;
    q_in  = '0;
    i_in  = '0;
    tick();
    tick();
    checkOutput("reset_busy", 48'(busy), 48'd0);
    checkOutput("reset_done", 48'(done), 48'd0);
    checkOutput("reset_q",    q_val_op, "+0.000");
    checkOutput("reset_i",    i_val_op, "+0.000");
    reset = 1'b0;
    tick();

    // Directed conversions
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].q, vecs[k].i, lat, stable);
      checkOutput($sformatf("v%0d_latency", k), 48'(lat), 48'd6);
      checkOutput($sformatf("v%0d_q", k), q_val_op, vecs[k].q_str);
      checkOutput($sformatf("v%0d_i", k), i_val_op, vecs[k].i_str);
      checkOutput($sformatf("v%0d_stable", k), 48'(stable), 48'd1);
      checkOutput($sformatf("v%0d_busy", k), 48'(busy), 48'd1);
      tick();
      checkOutput($sformatf("v%0d_done_drop", k), 48'(done), 48'd0);
      checkOutput($sformatf("v%0d_idle", k), 48'(busy), 48'd0);
    end

    // start held high: accepted at edges 0, 8 and 16, done at 6, 14, 22
    q_in  = 16'h0001;
    i_in  = 16'h0000;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("held_done_e%0d", k), 48'(done),
                  (k == 6 || k == 14) ? 48'd1 : 48'd0);
      checkOutput($sformatf("held_busy_e%0d", k), 48'(busy),
                  (k == 7 || k == 15) ? 48'd0 : 48'd1);
      if (k == 6) begin
        checkOutput("held_q_e6", q_val_op, "+0.000");
        checkOutput("held_i_e6", i_val_op, "+0.000");
      end
      if (k == 14) begin
        checkOutput("held_q_e14", q_val_op, "+1.000");
        checkOutput("held_i_e14", i_val_op, "-2.000");
      end
      if (k == 3) begin
        q_in = 16'h4000;
        i_in = 16'h8000;
      end
      if (k == 11) begin
        q_in = 16'h2000;
        i_in = 16'h0000;
      end
      if (k == 17) begin
        q_in = 16'h7FFF;
        i_in = 16'hFFFF;
      end
    end
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("held_last_wait", 48'(n), 48'd3);
    checkOutput("held_q_e22", q_val_op, "+0.500");
    checkOutput("held_i_e22", i_val_op, "+0.000");
    tick();
    tick();

    // Reset at edge 3 of a conversion aborts it
    q_in  = 16'h7FFF;
    i_in  = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("abort_busy", 48'(busy), 48'd0);
    checkOutput("abort_q",    q_val_op, "+0.000");
    checkOutput("abort_i",    i_val_op, "+0.000");
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    checkOutput("abort_no_done", 48'(seen_done), 48'd0);
    checkOutput("abort_q_hold",  q_val_op, "+0.000");

    // Half scale and zero, then hold through 50 idle cycles
    applyStimulus(16'h2000, 16'h0000, lat, stable);
    checkOutput("half_latency", 48'(lat), 48'd6);
    checkOutput("half_q", q_val_op, "+0.500");
    checkOutput("half_i", i_val_op, "+0.000");
    stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (q_val_op !== 48'("+0.500") || i_val_op !== 48'("+0.000") ||
          done !== 1'b0) stable = 1'b0;
    end
    checkOutput("half_hold", 48'(stable), 48'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
